// File: rtl/memory_8x32_pkg.sv
// Shared types and constants for the memory_8x32 arbiter slice.
// Geometry of the 8x32 SRAM plus an index-width helper.
package memory_8x32_pkg;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_DEPTH  = 8;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_data_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_8x32_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the search at rr_ptr.
// rr_ptr moves to the slot after the winner; holds when idle.
module rr_arbiter
    import memory_8x32_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    localparam int SW = IW + 1;

    logic [IW-1:0] rr_ptr;
    logic [SW-1:0] sum;
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        pos       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(N)) sum = sum - SW'(N);
            pos = sum[IW-1:0];
            // Grants are masked while reset is held.
            if (!found && req[pos] && !reset) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/memory_8x32_arbiter.sv
// Round-robin front end for a single-ported memory_8x32 SRAM.
// Muxes the winner onto the SRAM, tags reads, counts grants.
module memory_8x32_arbiter
    import memory_8x32_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16,
    localparam int IW = idx_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*3-1:0]      req_addr,
    input  logic [N_REQ*32-1:0]     req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic [2:0]              mem_address,
    output logic                    mem_write_enable,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data,
    input  logic                    stats_clear,
    output logic [N_REQ*CNT_W-1:0]  grant_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_any;
    logic             rd_pending_q;
    logic [IW-1:0]    tag_q;
    logic [CNT_W-1:0] cnt_q [N_REQ];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign grant_any = |grant;
    assign rsp_rdata = mem_read_data;

    // Idle cycles drive a harmless dummy read of address 0.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                mem_address      = req_addr[k*MEM_ADDR_W +: MEM_ADDR_W];
                mem_write_data   = req_wdata[k*MEM_DATA_W +: MEM_DATA_W];
                mem_write_enable = req_we[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            tag_q        <= '0;
        end else begin
            rd_pending_q <= grant_any & ~mem_write_enable;
            if (grant_any) tag_q <= grant_idx;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rsp_valid[j] = rd_pending_q && (tag_q == IW'(j));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (stats_clear) begin
                    cnt_q[k] <= '0;
                end else if (grant[k] && cnt_q[k] != CNT_MAX) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
        assign grant_count[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_memory_8x32_arbiter.sv
// Scoreboard bench for memory_8x32_arbiter with a behavioural SRAM.
// Directed scenarios followed by constrained-random traffic.
module tb_memory_8x32_arbiter;

    localparam int N  = 2;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N*3-1:0]  req_addr = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [2:0]      mem_address;
    logic            mem_write_enable;
    logic [31:0]     mem_write_data;
    logic [31:0]     mem_read_data = '0;
    logic            stats_clear = 1'b0;
    logic [N*CW-1:0] grant_count;

    memory_8x32_arbiter #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .stats_clear      (stats_clear),
        .grant_count      (grant_count)
    );

    always #5 clk = ~clk;

    // Behavioural memory_8x32: registered read, read data held on writes.
    logic [31:0] sram [8];
    logic [31:0] init_vals [8];
    logic        preload = 1'b1;

    always @(posedge clk) begin
        if (preload) sram <= init_vals;
        else if (mem_write_enable) sram[mem_address] <= mem_write_data;
        else mem_read_data <= sram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          req;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [8];
    int          last_grant;
    int          cnt_m [N];
    logic [N-1:0] acc = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   g;
        int   k;
        logic [2:0] a;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (reset) begin
                chk("rst_ready", 64'(req_ready), 64'(0));
                chk("rst_rsp", 64'(rsp_valid), 64'(0));
                chk("rst_we", 64'(mem_write_enable), 64'(0));
                chk("rst_addr", 64'(mem_address), 64'(0));
                exp_q.delete();
                last_grant = N - 1;
                for (int i = 0; i < N; i++) cnt_m[i] = 0;
                acc = '0;
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.req);
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                end else begin
                    chk("rsp_idle", 64'(rsp_valid), 64'(0));
                end
                for (int i = 0; i < N; i++)
                    chk("grant_count", 64'(grant_count[i*CW +: CW]),
                        64'(cnt_m[i]));
                g = -1;
                for (int i = 1; i <= N; i++) begin
                    k = (last_grant + i) % N;
                    if (g < 0 && req_valid[k]) g = k;
                end
                if (g < 0) begin
                    chk("ready_idle", 64'(req_ready), 64'(0));
                    chk("idle_we", 64'(mem_write_enable), 64'(0));
                    chk("idle_addr", 64'(mem_address), 64'(0));
                    chk("idle_wdata", 64'(mem_write_data), 64'(0));
                end else begin
                    a = req_addr[g*3 +: 3];
                    chk("req_ready", 64'(req_ready), 64'(1) << g);
                    chk("mem_addr", 64'(mem_address), 64'(a));
                    chk("mem_we", 64'(mem_write_enable), 64'(req_we[g]));
                    if (req_we[g]) begin
                        chk("mem_wdata", 64'(mem_write_data),
                            64'(req_wdata[g*32 +: 32]));
                        ref_mem[a] = req_wdata[g*32 +: 32];
                    end else begin
                        exp_q.push_back('{g, ref_mem[a], cyc + 1});
                    end
                    last_grant = g;
                end
                for (int i = 0; i < N; i++) begin
                    if (stats_clear) cnt_m[i] = 0;
                    else if (g == i && cnt_m[i] < CMAX) cnt_m[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input bit w,
                           input int a, input logic [31:0] d);
        req_valid[k]        = v;
        req_we[k]           = w;
        req_addr[k*3 +: 3]  = 3'(a);
        req_wdata[k*32 +: 32] = d;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) init_vals[i] = $urandom;
        init_vals[1] = 32'h11;
        init_vals[2] = 32'h22;
        ref_mem = init_vals;
        last_grant = N - 1;
        fork
            monitor();
        join_none

        tick();
        tick();
        reset = 1'b0;
        preload = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("idle_count0", 64'(grant_count[0 +: CW]), 64'(0));
        chk("idle_count1", 64'(grant_count[CW +: CW]), 64'(0));

        // Write then read of the same address from different requesters.
        tick();
        set_req(0, 1, 1, 5, 32'hDEADBEEF);
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 5, 0);
        tick();
        set_req(1, 0, 0, 0, 0);
        repeat (2) tick();

        // Both requesters contend for six cycles.
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        repeat (6) tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("alt_count0", 64'(grant_count[0 +: CW]), 64'(3));
        chk("alt_count1", 64'(grant_count[CW +: CW]), 64'(3));

        // Back-to-back reads from requester 1.
        tick();
        for (int a = 0; a < 4; a++) begin
            set_req(1, 1, 0, a, 0);
            tick();
        end
        set_req(1, 0, 0, 0, 0);
        repeat (2) tick();

        // Reset right after a read is accepted.
        set_req(0, 1, 0, 3, 0);
        tick();
        set_req(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1, 0, 4, 0);
        set_req(1, 1, 0, 6, 0);
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'(1));
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (2) tick();

        // Counter saturation and clear-over-increment.
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        set_req(0, 1, 0, 0, 0);
        repeat (CMAX + 2) tick();
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_count", 64'(grant_count[0 +: CW]), 64'(CMAX));
        tick();
        stats_clear = 1'b1;
        set_req(0, 1, 0, 7, 0);
        tick();
        stats_clear = 1'b0;
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_count", 64'(grant_count[0 +: CW]), 64'(0));
        tick();

        // Random traffic; fields held until accepted or dropped.
        repeat (400) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || acc[k]) begin
                    set_req(k, $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                            int'($urandom_range(0, 7)), $urandom);
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            stats_clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        req_valid = '0;
        stats_clear = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_8x32_arbiter.md
Name: memory_8x32_arbiter

Overview:
- Shares one single-ported memory_8x32 SRAM between N_REQ requesters using round-robin arbitration.
- Issues at most one access per clock: either a write or a read.
- Routes each read response back to the requester that issued it, 1 cycle after the access is accepted.
- Sits directly in front of memory_8x32. Keeps per-requester grant counters for performance visibility.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- CNT_W, 16, width of each per-requester saturating grant counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  request present, one bit per requester.
- req_ready  output  N_REQ  request accepted this cycle (one-hot or zero).
- req_we  input  N_REQ  1=write, 0=read, per requester.
- req_addr  input  N_REQ*3  packed addresses; requester k uses bits [3k+2:3k].
- req_wdata  input  N_REQ*32  packed write data; requester k uses bits [32k+31:32k].
- rsp_valid  output  N_REQ  read data valid for requester k (one-hot or zero).
- rsp_rdata  output  32  shared read-data bus; meaningful only when a rsp_valid bit is set.
- mem_address  output  3  to memory_8x32 address.
- mem_write_enable  output  1  to memory_8x32 write_enable.
- mem_write_data  output  32  to memory_8x32 write_data.
- mem_read_data  input  32  from memory_8x32 read_data (registered, 1-cycle latency).
- stats_clear  input  1  synchronous clear of all grant counters.
- grant_count  output  N_REQ*CNT_W  packed per-requester grant counts.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - rr_ptr=0.
  - rd_pending_q=0, tag_q=0.
  - grant_count all 0.
  - While reset is high: req_ready=0, rsp_valid=0, mem_write_enable=0, mem_address=0.
- Arbitration (combinational):
  - Select the first requester k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... mod N_REQ.
  - grant is one-hot; req_ready = grant. A handshake completes at the rising edge where req_valid[k] & req_ready[k].
- Memory drive:
  - With a grant: mem_address, mem_write_data and mem_write_enable come from the granted requester's fields (mem_write_enable = req_we[k]).
  - With no grant: mem_write_enable=0, mem_address=0, mem_write_data=0. This is a harmless dummy read and produces no response.
- Pointer update: on a grant to k, rr_ptr <= (k+1) mod N_REQ. With no grant, rr_ptr holds.
- Read tracking:
  - rd_pending_q <= grant_any & ~req_we[k].
  - tag_q <= k when granted; otherwise tag_q holds.
- Response:
  - rsp_valid[j] = rd_pending_q & (tag_q==j).
  - rsp_rdata = mem_read_data, passed straight through.
  - Read latency is exactly 1 cycle after the accept edge.
  - There is no response backpressure; requesters must sink responses.
- Throughput: one access per cycle. Back-to-back accesses from any mix of requesters are legal.
- Writes produce no response. memory_8x32 holds read_data during a write cycle; the arbiter ignores it.
- Write then read of the same address on consecutive cycles (any requesters): the read returns the new data.
- Requester-side rules:
  - Requester fields must stay stable while req_valid=1 and req_ready=0.
  - A requester may drop req_valid before it is granted. The arbiter accepts this and has no protocol checker.
- Counters:
  - grant_count[k] increments on each grant to k and saturates at 2^CNT_W-1.
  - stats_clear has priority over increment, clearing all counters at the next edge.
- Reset asserted mid-operation: a pending read response is dropped (rsp_valid=0 immediately); the arbiter restarts with requester 0 at highest priority.

Decomposition:
- Package memory_8x32_pkg:
  - MEM_ADDR_W=3, MEM_DATA_W=32, MEM_DEPTH=8.
  - typedef mem_addr_t (logic [2:0]), typedef mem_data_t (logic [31:0]).
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: clk, reset, req[N], grant[N], grant_idx.
  - Contains rr_ptr and its update.
- memory_8x32_arbiter instantiates rr_arbiter and holds the mux, the read-tag pipeline and the counters.

Test Plan:
- Reset, then both requesters idle for 3 cycles -> req_ready=0, rsp_valid=0, mem_write_enable=0, grant_count=0.
- Req0 writes 0xDEADBEEF to addr 5; next cycle req1 reads addr 5 -> rsp_valid=2'b10 one cycle after the read accept, rsp_rdata=0xDEADBEEF; req0 gets no rsp_valid.
- Both requesters hold req_valid (reads to addr 1 and 2, preloaded 0x11 and 0x22) for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_valid alternates with matching data; grant_count = 3 and 3.
- Req1 only, 4 back-to-back reads of addrs 0..3 -> granted every cycle; 4 consecutive responses in order, 1-cycle latency.
- Assert reset for 1 cycle immediately after a read is accepted -> no rsp_valid; after release, with both requesters valid, requester 0 is granted first.
- Force grant_count[0] to 0xFFFE with CNT_W=16, then 3 grants -> count sticks at 0xFFFF; stats_clear together with a grant -> count becomes 0.
